// File: rtl/watch_pkg.sv
// Shared definitions for the watch time/alarm entry path: FSM states, digit
// positions, per-position digit limits and keypad decode.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [2:0] H_TEN = 3'd0,
                           H_ONE = 3'd1,
                           M_TEN = 3'd2,
                           M_ONE = 3'd3,
                           S_TEN = 3'd4,
                           S_ONE = 3'd5;

    localparam logic [3:0] MAX_DIGIT [6] = '{4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] onehot);
        logic [3:0] bcd;
        bcd = '0;
        for (int i = 0; i < 10; i++) begin
            if (onehot[i]) bcd = 4'(i);
        end
        return bcd;
    endfunction

    // Hours are capped at 23, so the hour-ones limit depends on the hour-tens digit.
    function automatic logic [3:0] max_digit(input logic [2:0] pos, input logic [3:0] h_ten);
        if (pos == H_ONE && h_ten == 4'd2) return 4'd3;
        if (pos > S_ONE) return 4'd0;
        return MAX_DIGIT[pos];
    endfunction

endpackage

// File: rtl/time_entry_ctrl_keypad_edge.sv
// Keypad press detector: strobes once per single-key press, after the keypad
// has been all-zero; multi-key chords never strobe and hold off the next press.
module keypad_edge
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    output logic       key_stb,
    output logic [3:0] key_digit
);

    logic [9:0] key_prev;
    logic       single;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_prev <= '0;
        else     key_prev <= keypad;
    end

    assign single    = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    assign key_stb   = single && (key_prev == '0);
    assign key_digit = onehot_to_bcd(keypad);

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time/alarm setting controller: collects BCD digits into a shadow
// register, validates them by position and hands the result over a valid/ready load.
module time_entry_ctrl
    import watch_pkg::*;
#(
    parameter int TIMEOUT_MS   = 10000,
    parameter int ALARM_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_en,
    input  logic        target_sel,
    input  logic [9:0]  keypad,
    input  logic        ld_ready,
    output logic [23:0] ld_data,
    output logic        ld_time_valid,
    output logic        ld_alarm_valid,
    output logic [2:0]  cursor,
    output logic        busy,
    output logic        err
);

    localparam int               CNT_W      = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_MS - 1);
    localparam logic [2:0]       ALARM_LAST = 3'(ALARM_DIGITS - 1);

    state_t           state;
    logic             tgt;
    logic             valid;
    logic [2:0]       pos;
    logic [5:0][3:0]  dig;
    logic [5:0][3:0]  next_dig;
    logic [CNT_W-1:0] tmo_cnt;
    logic             key_stb;
    logic [3:0]       key_digit;
    logic             key_ok;
    logic [2:0]       last_pos;

    keypad_edge u_keypad_edge (
        .clk       (clk),
        .rst       (rst),
        .keypad    (keypad),
        .key_stb   (key_stb),
        .key_digit (key_digit)
    );

    assign key_ok   = key_digit <= max_digit(pos, dig[H_TEN]);
    assign last_pos = tgt ? ALARM_LAST : S_ONE;

    always_comb begin
        next_dig      = dig;
        next_dig[pos] = key_digit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tgt     <= 1'b0;
            valid   <= 1'b0;
            pos     <= '0;
            dig     <= '0;
            tmo_cnt <= '0;
            ld_data <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (entry_en) begin
                        state   <= ST_ENTRY;
                        tgt     <= target_sel;
                        pos     <= '0;
                        dig     <= '0;
                        tmo_cnt <= '0;
                    end
                end
                ST_ENTRY: begin
                    // Switch release aborts silently; a key edge outranks timer expiry.
                    if (!entry_en) begin
                        state <= ST_IDLE;
                        pos   <= '0;
                    end else if (key_stb) begin
                        tmo_cnt <= '0;
                        if (key_ok) begin
                            dig <= next_dig;
                            if (pos == last_pos) begin
                                state   <= ST_COMMIT;
                                pos     <= '0;
                                valid   <= 1'b1;
                                ld_data <= {next_dig[0], next_dig[1], next_dig[2],
                                            next_dig[3], next_dig[4], next_dig[5]};
                            end else begin
                                pos <= pos + 3'd1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (tmo_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        pos   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (ld_ready) begin
                        valid <= 1'b0;
                        state <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (!entry_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ld_time_valid  = valid & ~tgt;
    assign ld_alarm_valid = valid & tgt;
    assign busy           = (state != ST_IDLE);
    assign cursor         = pos;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: directed scenarios then random keypad traffic,
// all compared cycle by cycle against a behavioural model of the entry rules.
module tb_time_entry_ctrl;

    localparam int TMO    = 20;
    localparam int ADIG   = 4;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_COMMIT = 2, M_WAIT = 3;

    logic        clk;
    logic        rst;
    logic        entry_en;
    logic        target_sel;
    logic [9:0]  keypad;
    logic        ld_ready;
    logic [23:0] ld_data;
    logic        ld_time_valid;
    logic        ld_alarm_valid;
    logic [2:0]  cursor;
    logic        busy;
    logic        err;

    time_entry_ctrl #(.TIMEOUT_MS(TMO), .ALARM_DIGITS(ADIG)) dut (
        .clk            (clk),
        .rst            (rst),
        .entry_en       (entry_en),
        .target_sel     (target_sel),
        .keypad         (keypad),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_time_valid  (ld_time_valid),
        .ld_alarm_valid (ld_alarm_valid),
        .cursor         (cursor),
        .busy           (busy),
        .err            (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: tracks mode, collected digits and time since last key event.
    int          m_mode, m_tgt, m_cur, m_valid, m_err;
    int          m_dig [6];
    logic [9:0]  m_prev;
    logic [23:0] m_data;
    longint      now, m_last;

    logic       en_v, tsel_v, rdy_v;
    logic [9:0] kp_v;

    function automatic bit digit_fits(int p, int d);
        case (p)
            0:       return d * 10 <= 23;
            1:       return m_dig[0] * 10 + d <= 23;
            2, 4:    return d * 10 <= 59;
            default: return d <= 9;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_tgt = 0; m_cur = 0; m_valid = 0; m_err = 0;
        foreach (m_dig[i]) m_dig[i] = 0;
        m_prev = '0; m_data = '0; m_last = now;
    endtask

    task automatic model_clk();
        bit ev;
        int d;
        int final_pos;
        ev = (kp_v != 0) && (m_prev == 0) && ($countones(kp_v) == 1);
        d = 0;
        for (int i = 0; i < 10; i++) if (kp_v[i]) d = i;
        m_prev = kp_v;
        m_err  = 0;
        case (m_mode)
            M_IDLE: if (en_v) begin
                m_mode = M_ENTRY; m_tgt = tsel_v; m_cur = 0; m_last = now;
                foreach (m_dig[i]) m_dig[i] = 0;
            end
            M_ENTRY: begin
                final_pos = (m_tgt != 0) ? ADIG - 1 : 5;
                if (!en_v) begin
                    m_mode = M_IDLE; m_cur = 0;
                end else if (ev) begin
                    m_last = now;
                    if (digit_fits(m_cur, d)) begin
                        m_dig[m_cur] = d;
                        if (m_cur == final_pos) begin
                            m_mode = M_COMMIT; m_valid = 1; m_cur = 0;
                            m_data = '0;
                            for (int i = 0; i < 6; i++) m_data = m_data * 16 + 24'(m_dig[i]);
                        end else begin
                            m_cur++;
                        end
                    end else begin
                        m_err = 1;
                    end
                end else if (now - m_last >= TMO) begin
                    m_err = 1; m_mode = M_IDLE; m_cur = 0;
                end
            end
            M_COMMIT: if (rdy_v) begin
                m_valid = 0; m_mode = M_WAIT;
            end
            default: if (!en_v) m_mode = M_IDLE;
        endcase
        now++;
    endtask

    task automatic check_outs();
        chk("time_valid",  ld_time_valid,  (m_valid != 0) && (m_tgt == 0));
        chk("alarm_valid", ld_alarm_valid, (m_valid != 0) && (m_tgt != 0));
        chk("ld_data",     ld_data,        m_data);
        chk("cursor",      cursor,         m_cur);
        chk("busy",        busy,           m_mode != M_IDLE);
        chk("err",         err,            m_err);
    endtask

    task automatic step(input logic [9:0] kp);
        kp_v = kp;
        keypad = kp; entry_en = en_v; target_sel = tsel_v; ld_ready = rdy_v;
        @(posedge clk);
        model_clk();
        #1;
        check_outs();
    endtask

    task automatic press(input int d);
        step(10'b1 << d);
        step('0);
    endtask

    task automatic go_idle();
        en_v = 1'b0; rdy_v = 1'b1;
        step('0);
        step('0);
        step('0);
    endtask

    int at, cnt, hold, r, a, b;
    logic [9:0] kp;

    initial begin
        now = 0;
        en_v = 0; tsel_v = 0; rdy_v = 0; kp_v = '0;
        entry_en = 0; target_sel = 0; keypad = '0; ld_ready = 0;
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_time_valid", ld_time_valid, 0);
        chk("rst_alarm_valid", ld_alarm_valid, 0);
        chk("rst_data", ld_data, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Time entry 12:34:56 with ready already high
        en_v = 1; tsel_v = 0; rdy_v = 1;
        step('0);
        for (int d = 1; d <= 5; d++) press(d);
        step(10'b1 << 6);
        chk("te_vld", ld_time_valid, 1);
        chk("te_data", ld_data, 24'h123456);
        step('0);
        chk("te_vld_drop", ld_time_valid, 0);
        chk("te_wait_busy", busy, 1);
        go_idle();

        // Position validation: 2 then 4 rejected, then 3 accepted
        en_v = 1;
        step('0);
        press(2);
        step(10'b1 << 4);
        chk("val_err", err, 1);
        chk("val_cur1", cursor, 1);
        step('0);
        press(3);
        chk("val_cur2", cursor, 2);
        go_idle();

        // Alarm 07:30 with ready withheld for five cycles
        en_v = 1; tsel_v = 1; rdy_v = 0;
        step('0);
        press(0); press(7); press(3);
        step(10'b1);
        cnt = (ld_alarm_valid === 1'b1) ? 1 : 0;
        chk("al_data", ld_data, 24'h073000);
        for (int i = 0; i < 5; i++) begin
            step('0);
            if (ld_alarm_valid === 1'b1) cnt++;
            chk("al_no_time", ld_time_valid, 0);
        end
        rdy_v = 1;
        step('0);
        if (ld_alarm_valid === 1'b1) cnt++;
        chk("al_vld_cycles", cnt, 6);
        go_idle();
        tsel_v = 0;

        // Timeout after silence, then a key landing exactly on expiry
        en_v = 1;
        step('0);
        step(10'b1 << 1);
        at = 0;
        for (int i = 1; i <= 30; i++) begin
            step('0);
            if (at == 0 && err === 1'b1) begin
                at = i;
                chk("tmo_idle", busy, 0);
            end
        end
        chk("tmo_cycle", at, TMO);
        go_idle();
        en_v = 1;
        step('0);
        step(10'b1 << 1);
        for (int i = 1; i < TMO; i++) step('0);
        step(10'b1 << 2);
        chk("tmo_key_cur", cursor, 2);
        chk("tmo_key_err", err, 0);
        go_idle();

        // Abort by switch release after three digits
        en_v = 1;
        step('0);
        press(1); press(0); press(4);
        en_v = 0;
        step('0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_vld", ld_time_valid, 0);

        // Asynchronous reset while a load is pending
        en_v = 1; rdy_v = 0;
        step('0);
        press(2); press(3); press(5); press(9); press(5);
        step(10'b1 << 9);
        chk("rc_vld_before", ld_time_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rc_vld", ld_time_valid, 0);
        chk("rc_data", ld_data, 0);
        chk("rc_busy", busy, 0);
        chk("rc_cursor", cursor, 0);
        en_v = 0; entry_en = 0;
        #1 rst = 1'b0;
        model_reset();
        step('0);

        // Multi-hot chord is ignored until the keypad clears
        en_v = 1;
        step('0);
        step(10'b0000000110);
        chk("mh_cur", cursor, 0);
        chk("mh_err", err, 0);
        step(10'b0000000010);
        chk("mh_noedge", cursor, 0);
        step('0);
        step(10'b0000000010);
        chk("mh_accept", cursor, 1);
        step('0);

        // Random keypad, switch and ready traffic
        for (int c = 0; c < 4000; ) begin
            hold = ($urandom_range(0, 15) == 0) ? 25 : $urandom_range(1, 4);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                kp = '0;
            end else if (r < 9) begin
                kp = 10'b1 << $urandom_range(0, ($urandom_range(0, 1) == 0) ? 3 : 9);
            end else begin
                a = $urandom_range(0, 9);
                b = (a + 1 + $urandom_range(0, 8)) % 10;
                kp = (10'b1 << a) | (10'b1 << b);
            end
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 59) == 0) en_v = ~en_v;
                rdy_v  = 1'($urandom_range(0, 1));
                tsel_v = 1'($urandom_range(0, 1));
                step(kp);
                c++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/time_entry_ctrl.md
TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_MS, default 10000, meaning idle-key abort limit in clk cycles (1 kHz clock, so 1 cycle = 1 ms).
REQ-002 SHALL have parameter ALARM_DIGITS, default 4, meaning digits collected for an alarm target, with seconds forced to 0.
REQ-003 SHALL have port clk, input, 1 bit: 1 kHz system clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port entry_en, input, 1 bit: set-mode level (DIP switch); 1 requests entry.
REQ-006 SHALL have port target_sel, input, 1 bit: 0 selects the time counter, 1 selects the alarm; sampled on IDLE->ENTRY.
REQ-007 SHALL have port keypad, input, 10 bits: one-hot keys 0-9, bit n = digit n.
REQ-008 SHALL have port ld_ready, input, 1 bit: the destination accepts ld_data.
REQ-009 SHALL have port ld_data, output, 24 bits: packed BCD {h_ten,h_one,m_ten,m_one,s_ten,s_one}, MSB first.
REQ-010 SHALL have port ld_time_valid, output, 1 bit: load request to the time counter.
REQ-011 SHALL have port ld_alarm_valid, output, 1 bit: load request to the alarm.
REQ-012 SHALL have port cursor, output, 3 bits: index 0-5 of the next digit, for display blink.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port err, output, 1 bit: 1-cycle pulse on a rejected key or a timeout.

Function
REQ-015 SHALL implement states IDLE, ENTRY, COMMIT and WAIT_REL.
REQ-016 SHALL transition IDLE->ENTRY when entry_en=1, latching target_sel, cursor=0 and the shadow digits to 0.
REQ-017 SHALL accept a key only on a rising edge: keypad nonzero this cycle and all-zero the previous cycle.
REQ-018 SHALL ignore any keypad value with more than one bit set, with no err pulse and no edge credit until the keypad returns to zero.
REQ-019 SHALL validate digits by position:
- 0: 0-2
- 1: 0-9, or 0-3 if digit 0 = 2
- 2: 0-5
- 3: 0-9
- 4: 0-5
- 5: 0-9
REQ-020 SHALL handle a valid key by writing the shadow digit at cursor and incrementing cursor, in the cycle after the edge.
REQ-021 SHALL handle an invalid key by pulsing err and leaving cursor and the shadow digits unchanged.
REQ-022 SHALL transition ENTRY->COMMIT on the accepted final digit: position 5 for time, position ALARM_DIGITS-1 for alarm.
REQ-023 SHALL, in COMMIT, drive ld_data from the shadow register and hold the valid line matching the latched target high until ld_ready=1.
REQ-024 SHALL complete the transfer in the cycle where valid and ld_ready are both 1, deassert valid the next cycle, and go to WAIT_REL.
REQ-025 SHALL never assert ld_time_valid and ld_alarm_valid together.
REQ-026 SHALL hold ld_data stable while a valid line is high.
REQ-027 SHALL transition WAIT_REL->IDLE when entry_en=0, so one entry produces one load per switch cycle.
REQ-028 SHALL run a timeout counter in ENTRY that is cleared on any accepted or rejected key edge.
REQ-029 SHALL, when the counter reaches TIMEOUT_MS-1, pulse err and go to IDLE with no load.
REQ-030 SHALL give a key edge priority over a timeout expiry in the same cycle.
REQ-031 SHALL abort ENTRY to IDLE with no load and no err when entry_en falls.
REQ-032 SHALL let COMMIT complete regardless of entry_en, then pass through WAIT_REL.
REQ-033 SHALL make the timeout counter width clog2(TIMEOUT_MS) and saturate it, never wrap.
REQ-034 SHALL hold cursor at 0 outside ENTRY.

Reset
REQ-035 SHALL, on rst=1 and asynchronously, enter IDLE with ld_data=0, ld_time_valid=0, ld_alarm_valid=0, cursor=0, busy=0, err=0, the timeout counter at 0 and the key-previous register at 0.
REQ-036 SHALL, on reset in mid COMMIT, drop valid immediately with no transfer implied.

Structure
REQ-037 SHALL place the state enum, digit-index constants (H_TEN=0 through S_ONE=5), the per-position max-digit table and the one-hot-to-BCD decode function in shared package watch_pkg.
REQ-038 SHALL contain one sub-module, keypad_edge, which does edge detection, multi-hot rejection, and outputs key_stb and key_digit[3:0].

Verification
REQ-039 SHALL verify a time entry: entry_en=1, target_sel=0, keys 1,2,3,4,5,6, ld_ready=1 -> ld_time_valid for 1 cycle with ld_data=0x123456, then WAIT_REL.
REQ-040 SHALL verify validation: keys 2 then 4 -> err pulse, cursor stays 1; then key 3 -> cursor=2.
REQ-041 SHALL verify an alarm entry: target_sel=1, keys 0,7,3,0, ld_ready held 0 for 5 cycles -> ld_alarm_valid high for 6 cycles, ld_data=0x073000 stable, ld_time_valid stays 0.
REQ-042 SHALL verify timeout: TIMEOUT_MS=20, one key then silence -> err at cycle 20 after the key, IDLE, no valid; a key on the expiry cycle -> cursor advances, no err.
REQ-043 SHALL verify abort: entry_en falls after 3 digits -> IDLE, no load, no err; rst asserted during COMMIT -> all outputs 0 asynchronously.
REQ-044 SHALL verify multi-hot: keypad=10'b0000000110 -> no cursor change and no err; a subsequent single key is accepted only after the keypad returns to zero.
